concat_stream: RTL and testbench
================================

Name: concat_stream

Overview:
- Parametrised successor to the fixed byte-to-word concatenator used on the loader path (UART bytes -> 32-bit instruction/data words).
- Packs DATAW_IN-bit input chunks into DATAW_OUT-bit words.
- Adds a valid/ready handshake on both sides, a one-word output buffer with backpressure, and selectable chunk order.
- Sits between the UART RX byte stream and the instruction/data memory writer.

Parameters:
- DATAW_IN, 8, input chunk width in bits
- DATAW_OUT, 32, output word width; must equal DATAW_IN*CONCAT_NUM
- CONCAT_NUM, 4, chunks per output word; must be >=2
- CONCAT_LEN, 2, counter width, ceil(log2(CONCAT_NUM))
- LSB_FIRST, 1, 1: first chunk -> dout[DATAW_IN-1:0]; 0: first chunk -> dout[DATAW_OUT-1:DATAW_OUT-DATAW_IN]

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  din carries a chunk
- in_ready  out  1  block accepts a chunk this cycle
- din  in  DATAW_IN  input chunk
- out_valid  out  1  dout holds a complete word
- out_ready  in  1  consumer takes dout this cycle
- dout  out  DATAW_OUT  assembled word
- busy  out  1  accumulator holds 1..CONCAT_NUM-1 chunks
- (CONCAT_FLUSH_EN only) flush  in  1  request emission of partial word
- (CONCAT_FLUSH_EN only) out_last  out  1  word produced by flush
- (CONCAT_FLUSH_EN only) out_cnt  out  CONCAT_LEN+1  valid chunks in dout, 1..CONCAT_NUM

Behaviour:
- Reset (async assert, sync release) clears all state:
  - cnt=0, accumulator=0, out_valid=0, dout=0, busy=0, out_last=0, out_cnt=0
  - in_ready=1 from the first cycle after reset release.
- Accept: chunk is taken on a cycle with in_valid && in_ready.
  - It is written into slot cnt (slot position set by LSB_FIRST), then cnt increments.
- Completion: a chunk accepted with cnt==CONCAT_NUM-1 completes the word.
  - The full word moves to the output register on the same edge.
  - cnt wraps to 0; the accumulator is not required to be cleared.
  - out_valid=1 on the next cycle, i.e. one cycle after the last chunk is accepted.
- Output handshake:
  - dout is held stable while out_valid && !out_ready.
  - out_valid drops after a cycle with out_valid && out_ready, unless a new word completes on that same edge. In that case out_valid stays 1 and dout updates, with no bubble.
- Backpressure:
  - in_ready = !(cnt==CONCAT_NUM-1 && out_valid && !out_ready).
  - Chunks 0..CONCAT_NUM-2 are always accepted, even while the output is stalled.
  - No chunk is ever dropped or overwritten.
- Sustained throughput: one chunk per cycle with out_ready held at 1.
- busy = (cnt != 0).
- in_ready may depend combinationally on out_ready. No other input-to-output combinational path is allowed.
- Reset mid-word discards the partial accumulator and any pending output word.

Optional Feature:
- Macro: CONCAT_FLUSH_EN
- With macro:
  - flush, out_last and out_cnt ports exist.
  - Flush fires when flush=1 with cnt!=0 (after counting any chunk accepted that cycle) and the output register is free or draining that cycle.
  - On firing: the partial word goes to the output register with unfilled slots zeroed, out_last=1, out_cnt=number of chunks, and cnt resets to 0.
  - If the chunk accepted that cycle completes the word, it is emitted as a normal full word with out_last=1 and out_cnt=CONCAT_NUM.
  - flush with cnt==0 and no accepted chunk is ignored.
  - While a flush is blocked by a stalled output, in_ready=0 and the flush stays pending for as long as flush is held.
  - Normal words carry out_last=0 and out_cnt=CONCAT_NUM.
- Without macro: the ports are absent and a partial word waits indefinitely for further chunks.

Test Plan:
- Default params, LSB_FIRST=1, bytes 0x13,0x05,0x10,0x00 with out_ready=1 -> out_valid one cycle after the 4th accept, dout=0x00100513, in_ready stays 1.
- LSB_FIRST=0, same bytes -> dout=0x13051000.
- Hold out_ready=0 and stream 8 bytes 0x01..0x08:
  - first word 0x04030201 is held stable;
  - bytes 5-7 are accepted, then in_ready=0 with byte 0x08 presented;
  - on raising out_ready, 0x04030201 is taken, then 0x08070605 appears the next cycle.
- Continuous bytes 0x00..0x0B with out_ready=1 -> words 0x03020100, 0x07060504, 0x0B0A0908 on consecutive 4-cycle boundaries, no gaps.
- Assert rst after 2 bytes, then send 0xAA,0xBB,0xCC,0xDD -> dout=0xDDCCBBAA; no stale bytes appear.
- CONCAT_FLUSH_EN defined: bytes 0x11,0x22 then flush -> dout=0x00002211, out_last=1, out_cnt=2, busy=0.

Source files
------------

// File: rtl/concat_stream_if.sv
// concat_stream_if: chunk-in / word-out handshake bundle; flush, out_last and out_cnt exist only with CONCAT_FLUSH_EN
interface concat_stream_if #(
    parameter int DATAW_IN  = 8,
    parameter int DATAW_OUT = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAW_IN-1:0]  din;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAW_OUT-1:0] dout;
    logic                 busy;
`ifdef CONCAT_FLUSH_EN
    logic                                   flush;
    logic                                   out_last;
    logic [$clog2(DATAW_OUT/DATAW_IN):0]    out_cnt;
    modport master (output in_valid, din, out_ready, flush, input in_ready, out_valid, dout, busy, out_last, out_cnt);
    modport slave (input in_valid, din, out_ready, flush, output in_ready, out_valid, dout, busy, out_last, out_cnt);
`else
    modport master (output in_valid, din, out_ready, input in_ready, out_valid, dout, busy);
    modport slave (input in_valid, din, out_ready, output in_ready, out_valid, dout, busy);
`endif
endinterface

// File: rtl/concat_stream.sv
// concat_stream: packs DATAW_IN-bit chunks into DATAW_OUT-bit words with a one-word output buffer; CONCAT_FLUSH_EN adds partial-word flush
module concat_stream #(
    parameter int DATAW_IN   = 8,
    parameter int DATAW_OUT  = 32,
    parameter int CONCAT_NUM = 4,
    parameter int CONCAT_LEN = 2,
    parameter int LSB_FIRST  = 1
) (
    input  logic           clk,
    input  logic           rst,
    concat_stream_if.slave bus
);
    logic [CONCAT_LEN-1:0] cnt, pos;
    logic [DATAW_OUT-1:0]  acc, acc_nx, word;
    logic                  ovalid, fire, last, stall, emit;
    assign last = cnt == CONCAT_LEN'(CONCAT_NUM - 1);
    assign stall = ovalid && !bus.out_ready;
    assign fire = bus.in_valid && bus.in_ready;
    assign pos = LSB_FIRST != 0 ? cnt : CONCAT_LEN'(CONCAT_NUM - 1) - cnt;
    assign bus.out_valid = ovalid;
    assign bus.dout = word;
    assign bus.busy = cnt != '0;
`ifdef CONCAT_FLUSH_EN
    logic [CONCAT_LEN:0] n_after, ocnt;
    logic                olast;
    assign n_after = {1'b0, cnt} + (CONCAT_LEN + 1)'(fire);
    assign bus.in_ready = !(stall && (last || bus.flush));
    assign emit = (fire && last) || (bus.flush && n_after != '0 && !stall);
    assign bus.out_last = olast;
    assign bus.out_cnt = ocnt;
    // word metadata follows the output register; a flush on a completing chunk still marks it last
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            olast <= 1'b0;
            ocnt <= '0;
        end else if (emit) begin
            olast <= bus.flush;
            ocnt <= n_after;
        end
`else
    assign bus.in_ready = !(stall && last);
    assign emit = fire && last;
`endif
    // merge the accepted chunk into its slot
    always_comb begin
        acc_nx = acc;
        for (int k = 0; k < CONCAT_NUM; k++)
            if (fire && pos == CONCAT_LEN'(k)) acc_nx[k*DATAW_IN +: DATAW_IN] = bus.din;
    end
    // accumulator is cleared on emission so a partial word always carries zeroed unfilled slots
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            acc <= '0;
            ovalid <= 1'b0;
            word <= '0;
        end else begin
            cnt <= emit ? '0 : fire ? cnt + CONCAT_LEN'(1) : cnt;
            acc <= emit ? '0 : acc_nx;
            ovalid <= emit || stall;
            if (emit) word <= acc_nx;
        end
endmodule

// File: tb/tb_concat_stream.sv
// tb_concat_stream: directed bench for LSB-first and MSB-first instances driven in lockstep, scoreboard-checked
module tb_concat_stream;
    typedef struct packed {logic [31:0] w; logic last; logic [2:0] n;} exp_t;
    logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] din = 8'h00;
    int         checks = 0, errors = 0, cyc = 0;
    exp_t       ql[$], qm[$], el, em;
    logic [7:0] chunks[$];
    int         pops[$];
    concat_stream_if #(.DATAW_IN(8), .DATAW_OUT(32)) bl(), bm();
    assign bl.in_valid = in_valid;
    assign bl.din = din;
    assign bl.out_ready = out_ready;
    assign bm.in_valid = in_valid;
    assign bm.din = din;
    assign bm.out_ready = out_ready;
`ifdef CONCAT_FLUSH_EN
    logic flush = 1'b0;
    assign bl.flush = flush;
    assign bm.flush = flush;
`endif
    concat_stream #(.LSB_FIRST(1)) dl (.clk(clk), .rst(rst), .bus(bl));
    concat_stream #(.LSB_FIRST(0)) dm (.clk(clk), .rst(rst), .bus(bm));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        din = b;
        @(negedge clk);
        while (!bl.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n == 50) chk("accept_timeout", bl.in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    always @(negedge clk) if (!rst) begin
        if (in_valid && bl.in_ready) begin
            chunks.push_back(din);
            if (chunks.size() == 4) begin
                ql.push_back({chunks[3], chunks[2], chunks[1], chunks[0], 1'b0, 3'd4});
                qm.push_back({chunks[0], chunks[1], chunks[2], chunks[3], 1'b0, 3'd4});
                chunks.delete();
            end
        end
        if (bl.out_valid && out_ready) begin
            pops.push_back(cyc);
            chk("lsb_word_expected", 64'(ql.size() > 0), 1);
            if (ql.size() > 0) begin
                el = ql.pop_front();
                chk("lsb_dout", bl.dout, el.w);
`ifdef CONCAT_FLUSH_EN
                chk("lsb_out_last", bl.out_last, el.last);
                chk("lsb_out_cnt", bl.out_cnt, el.n);
`endif
            end
        end
        if (bm.out_valid && out_ready) begin
            chk("msb_word_expected", 64'(qm.size() > 0), 1);
            if (qm.size() > 0) begin
                em = qm.pop_front();
                chk("msb_dout", bm.dout, em.w);
`ifdef CONCAT_FLUSH_EN
                chk("msb_out_last", bm.out_last, em.last);
                chk("msb_out_cnt", bm.out_cnt, em.n);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bl.out_valid, 0);
        chk("rst_dout", bl.dout, 0);
        chk("rst_busy", bl.busy, 0);
        chk("rst_in_ready", bl.in_ready, 1);
        @(posedge clk);
        #1;
        send(8'h13); send(8'h05); send(8'h10);
        chk("t1_busy_partial", bl.busy, 1);
        chk("t1_valid_early", bl.out_valid, 0);
        send(8'h00);
        chk("t1_valid_latency", bl.out_valid, 1);
        chk("t1_in_ready", bl.in_ready, 1);
        chk("t1_busy_wrapped", bl.busy, 0);
        chk("t1_dout_lsb", bl.dout, 32'h00100513);
        chk("t1_dout_msb", bm.dout, 32'h13051000);
        repeat (2) @(posedge clk);
        #1 chk("t1_valid_drop", bl.out_valid, 0);
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i));
        chk("t2_valid", bl.out_valid, 1);
        chk("t2_word1", bl.dout, 32'h04030201);
        for (int i = 5; i <= 7; i++) send(8'(i));
        in_valid = 1'b1;
        din = 8'h08;
        repeat (3) @(posedge clk);
        #1;
        chk("t2_in_ready_low", bl.in_ready, 0);
        chk("t2_word1_held", bl.dout, 32'h04030201);
        chk("t2_valid_held", bl.out_valid, 1);
        chk("t2_busy", bl.busy, 1);
        out_ready = 1'b1;
        send(8'h08);
        chk("t2_no_bubble", bl.out_valid, 1);
        chk("t2_word2", bl.dout, 32'h08070605);
        repeat (2) @(posedge clk);
        #1 pops.delete();
        for (int i = 0; i < 12; i++) send(8'(i));
        repeat (3) @(posedge clk);
        #1 chk("t3_word_count", pops.size(), 3);
        if (pops.size() == 3) begin
            chk("t3_gap1", pops[1] - pops[0], 4);
            chk("t3_gap2", pops[2] - pops[1], 4);
        end
        send(8'h55); send(8'h66);
        rst = 1'b1;
        chunks.delete();
        #1 chk("t4_busy_in_reset", bl.busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t4_valid_after_reset", bl.out_valid, 0);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        chk("t4_dout_lsb", bl.dout, 32'hDDCCBBAA);
        chk("t4_dout_msb", bm.dout, 32'hAABBCCDD);
        repeat (2) @(posedge clk);
        #1;
`ifdef CONCAT_FLUSH_EN
        send(8'h11); send(8'h22);
        chunks.delete();
        ql.push_back({32'h00002211, 1'b1, 3'd2});
        qm.push_back({32'h11220000, 1'b1, 3'd2});
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("t5_busy", bl.busy, 0);
        chk("t5_valid", bl.out_valid, 1);
        chk("t5_out_last", bl.out_last, 1);
        chk("t5_out_cnt", bl.out_cnt, 2);
        chk("t5_dout", bl.dout, 32'h00002211);
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("t5_empty_flush_ignored", bl.out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
`endif
        chk("lsb_scoreboard_empty", ql.size(), 0);
        chk("msb_scoreboard_empty", qm.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
